// File: rtl/arcade_input_mapper.sv
// rtl/arcade_input_mapper.sv - PS/2 + joystick merge, rotation, SOCD, autofire and coin stretch per player
module arcade_input_mapper #(
    parameter int          PLAYERS         = 2,
    parameter logic [15:0] COIN_PULSE      = 16'd50000,
    parameter logic [19:0] AF_HALF         = 20'd400000,
    parameter bit          COIN_FROM_START = 1'b1
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [10:0]            ps2_key,
    input  logic [16*PLAYERS-1:0]  joystick,
    input  logic [1:0]             rotate,
    input  logic                   merge,
    input  logic [PLAYERS-1:0]     autofire_en,
    input  logic                   socd_clean,
    output logic [4*PLAYERS-1:0]   dir,
    output logic [PLAYERS-1:0]     fire,
    output logic [PLAYERS-1:0]     start,
    output logic [PLAYERS-1:0]     coin
);

    logic        r_old_toggle;
    logic [14:0] r_keys;
    logic [7:0]  w_joy_or;
    logic        w_unused;

    assign w_unused = ^{ps2_key[8], joystick};

    // Held-key bits: [3:0] P0 U/D/L/R, [5:4] P0 fire, 6 start0, 7 coin0, [14:8] same for P1
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_old_toggle <= 1'b0;
            r_keys       <= '0;
        end else begin
            r_old_toggle <= ps2_key[10];
            if (ps2_key[10] != r_old_toggle) begin
                case (ps2_key[7:0])
                    8'h75: r_keys[0]  <= ps2_key[9];
                    8'h72: r_keys[1]  <= ps2_key[9];
                    8'h6B: r_keys[2]  <= ps2_key[9];
                    8'h74: r_keys[3]  <= ps2_key[9];
                    8'h29: r_keys[4]  <= ps2_key[9];
                    8'h14: r_keys[5]  <= ps2_key[9];
                    8'h05: r_keys[6]  <= ps2_key[9];
                    8'h2E: r_keys[7]  <= ps2_key[9];
                    8'h2D: r_keys[8]  <= ps2_key[9];
                    8'h2B: r_keys[9]  <= ps2_key[9];
                    8'h23: r_keys[10] <= ps2_key[9];
                    8'h34: r_keys[11] <= ps2_key[9];
                    8'h1C: r_keys[12] <= ps2_key[9];
                    8'h06: r_keys[13] <= ps2_key[9];
                    8'h36: r_keys[14] <= ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_joy_or = 8'd0;
        for (int i = 0; i < PLAYERS; i++) begin
            w_joy_or = w_joy_or | joystick[16*i +: 8];
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [7:0]  w_kbd;
        logic [7:0]  w_js;
        logic        w_js_start;
        logic [7:0]  w_raw;
        logic [3:0]  w_rot;
        logic [3:0]  w_dir;
        logic        w_raw_start;
        logic        w_coin_req;
        logic [3:0]  r_dir;
        logic        r_fire;
        logic        r_start;
        logic        r_coin;
        logic        r_coin_req_d;
        logic [15:0] r_coin_cnt;
        logic [19:0] r_af_cnt;
        logic        r_af_ph;

        // Keyboard state rearranged into joystick bit order
        if (p == 0) begin : g_kbd0
            assign w_kbd      = {r_keys[7], 1'b0, r_keys[6], r_keys[4] | r_keys[5],
                                 r_keys[0], r_keys[1], r_keys[2], r_keys[3]};
            assign w_js_start = merge ? w_joy_or[5] : joystick[5];
        end else if (p == 1) begin : g_kbd1
            assign w_kbd      = {r_keys[14], 1'b0, r_keys[13], r_keys[12],
                                 r_keys[8], r_keys[9], r_keys[10], r_keys[11]};
            assign w_js_start = merge ? w_joy_or[6] : joystick[16*p+6];
        end else begin : g_kbdn
            assign w_kbd      = 8'd0;
            assign w_js_start = joystick[16*p+5];
        end

        if (p == 0) begin : g_sel0
            assign w_js = merge ? w_joy_or : joystick[7:0];
        end else begin : g_seln
            assign w_js = merge ? 8'd0 : joystick[16*p +: 8];
        end

        assign w_raw       = w_kbd | w_js;
        assign w_raw_start = w_kbd[5] | w_js_start;
        assign w_coin_req  = w_raw[7] | (COIN_FROM_START & w_raw_start);

        // w_rot / w_dir are {right,left,down,up}; w_raw[3:0] is {up,down,left,right}
        always_comb begin
            w_rot = 4'd0;
            case (rotate)
                2'd0: w_rot = {w_raw[0], w_raw[1], w_raw[2], w_raw[3]};
                2'd1: w_rot = {w_raw[3], w_raw[2], w_raw[0], w_raw[1]};
                2'd2: w_rot = {w_raw[1], w_raw[0], w_raw[3], w_raw[2]};
                2'd3: w_rot = {w_raw[2], w_raw[3], w_raw[1], w_raw[0]};
                default: w_rot = 4'd0;
            endcase
            w_dir = w_rot;
            if (socd_clean) begin
                if (w_rot[0] && w_rot[1]) w_dir[1:0] = 2'b00;
                if (w_rot[2] && w_rot[3]) w_dir[3:2] = 2'b00;
            end
        end

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                r_dir        <= 4'd0;
                r_fire       <= 1'b0;
                r_start      <= 1'b0;
                r_coin       <= 1'b0;
                r_coin_req_d <= 1'b0;
                r_coin_cnt   <= 16'd0;
                r_af_cnt     <= 20'd0;
                r_af_ph      <= 1'b1;
            end else begin
                r_dir   <= w_dir;
                r_start <= w_raw_start;

                if (w_raw[4] && autofire_en[p]) begin
                    r_fire <= r_af_ph;
                    if (r_af_cnt == AF_HALF - 20'd1) begin
                        r_af_cnt <= 20'd0;
                        r_af_ph  <= ~r_af_ph;
                    end else begin
                        r_af_cnt <= r_af_cnt + 20'd1;
                    end
                end else begin
                    r_fire   <= w_raw[4];
                    r_af_cnt <= 20'd0;
                    r_af_ph  <= 1'b1;
                end

                // Only an edge seen while idle starts a pulse; a held request never retriggers
                r_coin_req_d <= w_coin_req;
                if (w_coin_req && !r_coin_req_d && r_coin_cnt == 16'd0) begin
                    r_coin_cnt <= COIN_PULSE;
                end else if (r_coin_cnt != 16'd0) begin
                    r_coin_cnt <= r_coin_cnt - 16'd1;
                end
                r_coin <= (r_coin_cnt != 16'd0);
            end
        end

        assign dir[4*p +: 4] = r_dir;
        assign fire[p]       = r_fire;
        assign start[p]      = r_start;
        assign coin[p]       = r_coin;
    end

endmodule
